waterlight_pattern_gen: RTL and testbench
=========================================

# waterlight_pattern_gen

Downstream consumer of the AHB-lite water-light register slave: takes the latched mode byte, the 32-bit speed word and the write-strobe clear pulse, and generates the 8-bit LED pattern. It contains a programmable prescaler that produces step ticks and a small pattern state machine that advances the LED vector once per tick. Output drives the board LED pins directly (active-high).

## Interface
- No parameters; LED width fixed at 8, speed width fixed at 32.
- HCLK  in  1  system clock, shared with the AHB-lite fabric.
- HRESETn  in  1  asynchronous active-low reset.
- WaterLight_mode  in  8  pattern select from register slave.
- WaterLight_speed  in  32  prescaler terminal count; step period = speed+1 HCLK cycles.
- pwm_cnt_clear  in  1  single-cycle pulse, asserted in the AHB address phase of any write to the register slave.
- LED  out  8  pattern output; reset 8'h00.
- step  out  1  one-cycle pulse on every pattern advance; reset 0.

## Operation
- Modes, constants shared via package: OFF=0x00, LEFT=0x01, RIGHT=0x02, FLASH=0x03, BOUNCE=0x04; any other value behaves as OFF.
- Initial pattern loaded on reload: OFF 0x00, LEFT 0x01, RIGHT 0x80, FLASH 0xFF, BOUNCE 0x01 with direction=left.
- Per tick: LEFT rotate left (0x80→0x01); RIGHT rotate right (0x01→0x80); FLASH toggle 0xFF↔0x00; BOUNCE shift in current direction, reverse direction upon reaching 0x80 or 0x01 (sequence 01,02,…,80,40,…,01,02,…, no repeated endpoint); OFF hold 0x00, no step pulse.
- Prescaler: 32-bit counter cnt; when cnt >= speed: tick, cnt←0; else cnt←cnt+1. Compare is >=, so lowering speed below the running count ticks on the next cycle. speed=0 ticks every cycle.
- Reload: the register slave updates the mode/speed registers two cycles after the clear pulse. pwm_cnt_clear is delayed through a 2-stage shift (clr_d1, clr_d2). While cnt_clear, clr_d1 or clr_d2 is high, cnt is forced to 0 and ticks are suppressed. On clr_d2, LED←initial pattern of the current mode, direction reset, mode_q←mode.
- Mode change without clear (mode != mode_q): treated identically to clr_d2, i.e. immediate reload and cnt←0.
- Reload takes priority over a coincident tick; step is not pulsed on a reload.
- A new pwm_cnt_clear arriving while a reload is pending restarts the delay (shift register naturally re-arms); reload still occurs exactly two cycles after the last pulse.
- Speed-only writes also reload: pattern restarts from its initial value.

## Timing
- Reset: LED=0x00, step=0, cnt=0, clr_d1/clr_d2=0, mode_q=0x00, direction=left.
- pwm_cnt_clear high in cycle T → LED shows initial pattern of the new mode from cycle T+3. First step pulse occurs in cycle T+3+speed+1; LED changes on that same cycle's closing edge (step and new LED are registered together, visible in T+4+speed).
- In steady state, step and LED update are spaced exactly speed+1 cycles apart.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-pattern clears all state asynchronously; after release the block is in OFF until a reload sees a non-zero mode.

## Structure
- Package waterlight_pkg: mode constants, LED width, initial-pattern function per mode.
- Sub-module waterlight_tick_gen: 32-bit prescaler with clear/hold input and >= compare, one-cycle tick output.
- Top: clear delay line, mode_q compare, pattern register and direction flag, next-pattern logic.

## Test plan
- Reset then clear pulse with mode=0x01, speed=3 → LED 0x01 at T+3, then 0x02, 0x04 every 4 cycles, wraps 0x80→0x01.
- mode=0x04, speed=0 → LED 01,02,04,…,80,40,…,01,02 one per cycle; step high every cycle after reload.
- mode=0x03, speed=9 → LED alternates 0xFF/0x00 every 10 cycles; mode=0x07 → LED 0x00, step never asserted.
- Running LEFT with speed=1000, cnt≈500; write speed=10 → clear restarts pattern at 0x01, first step 11 cycles after reload.
- Two clear pulses 1 cycle apart → single reload exactly 3 cycles after the second pulse; no step in between.
- Assert HRESETn low mid-BOUNCE → LED=0x00, step=0 immediately (asynchronous), remains OFF after release.

Source files
------------

// File: rtl/waterlight_pkg.sv
// Shared constants and helpers for the water-light LED pattern generator.
// Mode encodings match the register slave's mode byte.
package waterlight_pkg;

    localparam int LED_W = 8;
    localparam int SPD_W = 32;

    localparam logic [7:0] MODE_OFF    = 8'h00;
    localparam logic [7:0] MODE_LEFT   = 8'h01;
    localparam logic [7:0] MODE_RIGHT  = 8'h02;
    localparam logic [7:0] MODE_FLASH  = 8'h03;
    localparam logic [7:0] MODE_BOUNCE = 8'h04;

    localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

    typedef enum logic [2:0] {
        PAT_OFF,
        PAT_LEFT,
        PAT_RIGHT,
        PAT_FLASH,
        PAT_BOUNCE
    } pat_e;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    // Unknown mode bytes fall back to OFF.
    function automatic pat_e decode_mode(input logic [7:0] mode);
        pat_e p;
        case (mode)
            MODE_LEFT:   p = PAT_LEFT;
            MODE_RIGHT:  p = PAT_RIGHT;
            MODE_FLASH:  p = PAT_FLASH;
            MODE_BOUNCE: p = PAT_BOUNCE;
            default:     p = PAT_OFF;
        endcase
        return p;
    endfunction

    function automatic logic [LED_W-1:0] init_pattern(input pat_e p);
        logic [LED_W-1:0] v;
        case (p)
            PAT_LEFT:   v = LED_LSB;
            PAT_RIGHT:  v = LED_MSB;
            PAT_FLASH:  v = '1;
            PAT_BOUNCE: v = LED_LSB;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/waterlight_tick_gen.sv
// Programmable prescaler: one-cycle tick every speed+1 cycles.
// hold_i forces the count to zero and suppresses the tick.
module waterlight_tick_gen
    import waterlight_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic [SPD_W-1:0] speed_i,
    output logic             tick_o
);

    logic [SPD_W-1:0] cnt_q;
    logic [SPD_W-1:0] cnt_d;
    logic             hit;

    // >= so a speed lowered below the running count ticks at once.
    assign hit = (cnt_q >= speed_i);

    always_comb begin
        cnt_d  = cnt_q + {{(SPD_W-1){1'b0}}, 1'b1};
        tick_o = 1'b0;
        if (hold_i) begin
            cnt_d = '0;
        end else if (hit) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/waterlight_pattern_gen.sv
// LED pattern generator fed by the AHB-lite water-light register slave.
// Reloads two cycles after the last write strobe or on any mode change.
module waterlight_pattern_gen
    import waterlight_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [7:0]       WaterLight_mode,
    input  logic [SPD_W-1:0] WaterLight_speed,
    input  logic             pwm_cnt_clear,
    output logic [LED_W-1:0] LED,
    output logic             step
);

    logic             clr_d1_q;
    logic             clr_d2_q;
    logic [7:0]       mode_q;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             step_q;
    logic             step_d;
    logic             reload;
    logic             hold;
    logic             tick;
    pat_e             pat_cur;

    assign pat_cur = decode_mode(mode_q);

    // A newer strobe still in the delay line re-arms the reload.
    assign reload = (clr_d2_q & ~clr_d1_q & ~pwm_cnt_clear)
                  | (WaterLight_mode != mode_q);
    assign hold   = pwm_cnt_clear | clr_d1_q | clr_d2_q | reload;

    waterlight_tick_gen u_tick (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .hold_i  (hold),
        .speed_i (WaterLight_speed),
        .tick_o  (tick)
    );

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (reload) begin
            led_d = init_pattern(decode_mode(WaterLight_mode));
            dir_d = DIR_LEFT;
        end else if (tick) begin
            step_d = (pat_cur != PAT_OFF);
            unique case (pat_cur)
                PAT_LEFT:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                PAT_RIGHT:  led_d = {led_q[0], led_q[LED_W-1:1]};
                PAT_FLASH:  led_d = ~led_q;
                PAT_BOUNCE: begin
                    led_d = (dir_q == DIR_RIGHT) ? (led_q >> 1) : (led_q << 1);
                    if (led_d == LED_MSB) begin
                        dir_d = DIR_RIGHT;
                    end else if (led_d == LED_LSB) begin
                        dir_d = DIR_LEFT;
                    end
                end
                default: led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            clr_d1_q <= 1'b0;
            clr_d2_q <= 1'b0;
            mode_q   <= MODE_OFF;
            led_q    <= '0;
            dir_q    <= DIR_LEFT;
            step_q   <= 1'b0;
        end else begin
            clr_d1_q <= pwm_cnt_clear;
            clr_d2_q <= clr_d1_q;
            if (reload) begin
                mode_q <= WaterLight_mode;
            end
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign LED  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_waterlight_pattern_gen.sv
// Self-checking bench for waterlight_pattern_gen.
// Expected LED/step derive from elapsed cycles since each reload.
module tb_waterlight_pattern_gen;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [7:0]  WaterLight_mode;
    logic [31:0] WaterLight_speed;
    logic        pwm_cnt_clear;
    logic [7:0]  LED;
    logic        step;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          r_cyc;
    logic [7:0]  m_mode;
    int unsigned m_spd;
    bit          frozen;
    logic [7:0]  frz_led;

    always #5 HCLK = ~HCLK;

    waterlight_pattern_gen dut (
        .HCLK             (HCLK),
        .HRESETn          (HRESETn),
        .WaterLight_mode  (WaterLight_mode),
        .WaterLight_speed (WaterLight_speed),
        .pwm_cnt_clear    (pwm_cnt_clear),
        .LED              (LED),
        .step             (step)
    );

    function automatic logic [7:0] pat(input logic [7:0] mode,
                                       input int unsigned k);
        int unsigned p;
        logic [7:0] one;
        one = 8'h01;
        case (mode)
            8'h01: return one << (k % 8);
            8'h02: return 8'h80 >> (k % 8);
            8'h03: return (k % 2 == 0) ? 8'hFF : 8'h00;
            8'h04: begin
                p = k % 14;
                return (p <= 7) ? (one << p) : (one << (14 - p));
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_led(input int c);
        int unsigned d;
        if (frozen) return frz_led;
        d = c - r_cyc;
        return pat(m_mode, d / (m_spd + 1));
    endfunction

    function automatic logic exp_step(input int c);
        int unsigned d;
        if (frozen) return 1'b0;
        if (m_mode == 8'h00 || m_mode > 8'h04) return 1'b0;
        d = c - r_cyc;
        return (d > 0) && (d % (m_spd + 1) == 0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge HCLK);
        #1;
        cyc++;
        chk("led", LED, exp_led(cyc));
        chk("step", {7'd0, step}, {7'd0, exp_step(cyc)});
    endtask

    task automatic run(input int n);
        repeat (n) adv();
    endtask

    task automatic clr_pulse();
        if (!frozen) begin
            frz_led = exp_led(cyc);
            frozen  = 1'b1;
        end
        pwm_cnt_clear = 1'b1;
        adv();
        pwm_cnt_clear = 1'b0;
    endtask

    task automatic apply(input logic [7:0] mode, input int unsigned spd);
        WaterLight_mode  = mode;
        WaterLight_speed = spd;
        m_mode = mode;
        m_spd  = spd;
        r_cyc  = cyc + 1;
        frozen = 1'b0;
    endtask

    // Slave updates its registers two cycles after the strobe.
    task automatic write(input logic [7:0] mode, input int unsigned spd);
        clr_pulse();
        adv();
        apply(mode, spd);
    endtask

    initial begin
        HRESETn          = 1'b0;
        WaterLight_mode  = 8'h00;
        WaterLight_speed = 32'd0;
        pwm_cnt_clear    = 1'b0;
        m_mode = 8'h00;
        m_spd  = 0;
        frozen = 1'b0;
        r_cyc  = 0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_led", LED, 8'h00);
        chk("rst_step", {7'd0, step}, 8'h00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        run(5);

        write(8'h01, 3);
        run(40);

        write(8'h04, 0);
        run(30);

        write(8'h03, 9);
        run(45);
        write(8'h07, 5);
        run(30);

        write(8'h01, 1000);
        run(500);
        write(8'h01, 10);
        run(30);

        clr_pulse();
        clr_pulse();
        adv();
        apply(8'h02, 2);
        run(20);

        apply(8'h03, m_spd);
        run(15);

        repeat (14) begin
            logic [7:0] nm;
            nm = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0 && nm != m_mode) begin
                apply(nm, m_spd);
            end else begin
                write(nm, $urandom_range(0, 6));
            end
            run($urandom_range(5, 40));
        end

        write(8'h04, 2);
        run(20);
        #2;
        HRESETn         = 1'b0;
        WaterLight_mode = 8'h00;
        #1;
        chk("async_led", LED, 8'h00);
        chk("async_step", {7'd0, step}, 8'h00);
        m_mode = 8'h00;
        frozen = 1'b0;
        r_cyc  = cyc;
        run(3);
        @(negedge HCLK);
        HRESETn = 1'b1;
        run(20);
        write(8'h04, 1);
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
